// File: rtl/inverse_biquad_seq_if.sv
// inverse_biquad_seq_if
//   Sample-rate traffic bundle for inverse_biquad_seq.
//   valid_in   : upstream -> block, sample_in carries x[n]
//   ready_in   : block -> upstream, block can accept a sample this cycle
//   sample_in  : upstream -> block, signed 32-bit x[n]
//   sample_out : block -> downstream, signed 32-bit y[n], held between results
//   valid_out  : block -> downstream, one-cycle pulse marking a new sample_out
//   Modports: master = sample source/sink side, slave = the filter.
interface inverse_biquad_seq_if;
  logic               valid_in;
  logic               ready_in;
  logic signed [31:0] sample_in;
  logic signed [31:0] sample_out;
  logic               valid_out;

  modport master (
    output valid_in,
    output sample_in,
    input  ready_in,
    input  sample_out,
    input  valid_out
  );

  modport slave (
    input  valid_in,
    input  sample_in,
    output ready_in,
    output sample_out,
    output valid_out
  );
endinterface

// File: rtl/inverse_biquad_seq.sv
// inverse_biquad_seq
//   Inverse (pole/zero-swapped) biquad: y = A(z)/B(z) applied to x, i.e.
//     y[n] = ((x[n] + A1*x[n-1] + A2*x[n-2] - B1*y[n-1] - B2*y[n-2]) * B0_INV) >>> SHIFT
//   where every product is a full 64-bit product floored by >>> SHIFT before
//   accumulation. One 32x32 multiplier is time-shared across four MAC cycles,
//   followed by a wide normalising multiply by B0_INV.
//   One sample is accepted per 7 cycles; valid_out pulses 6 cycles after accept.
// Ports:
//   clk_in : system clock
//   rst_in : synchronous active-high reset (clears state, accumulator, history, outputs)
//   bus    : inverse_biquad_seq_if.slave (valid_in/ready_in/sample_in in,
//            sample_out/valid_out out)
// Build option:
//   INVBIQ_SATURATE_EN defined   -> result clamped to [-2^31, 2^31-1]
//   INVBIQ_SATURATE_EN undefined -> result wraps (low 32 bits)
module inverse_biquad_seq #(
  parameter int                 SHIFT  = 20,
  parameter logic signed [31:0] A1     = 32'sd0,
  parameter logic signed [31:0] A2     = 32'sd0,
  parameter logic signed [31:0] B1     = 32'sd0,
  parameter logic signed [31:0] B2     = 32'sd0,
  parameter logic signed [31:0] B0_INV = 32'sd1048576
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  inverse_biquad_seq_if.slave   bus
);

  localparam int DATA_W = 32;
  localparam int COEF_W = 32;
  localparam int ACC_W  = 64;
  localparam int NRM_W  = 96;

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, NORM, OUT} state_t;

  state_t                    state_q;
  logic signed [DATA_W-1:0]  x_cur_q, x1_q, x2_q, y1_q, y2_q, y_res_q;
  logic signed [DATA_W-1:0]  sample_out_q;
  logic                      valid_out_q;
  logic signed [ACC_W-1:0]   acc_q;

  logic signed [COEF_W-1:0]  mul_c;
  logic signed [DATA_W-1:0]  mul_x;
  logic                      mul_sub;
  logic signed [ACC_W-1:0]   prod;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [NRM_W-1:0]   nrm_prod;
  logic signed [NRM_W-1:0]   nrm_shift;
  logic signed [DATA_W-1:0]  y_red;

  // Collapse the normalised 96-bit result to the 32-bit output word.
  function automatic logic signed [DATA_W-1:0] reduce(input logic signed [NRM_W-1:0] v);
`ifdef INVBIQ_SATURATE_EN
    if (v > 96'sh0000_0000_0000_0000_7FFF_FFFF)
      return 32'sh7FFF_FFFF;
    else if (v < -96'sh0000_0000_0000_0000_8000_0000)
      return 32'sh8000_0000;
    else
      return $signed(v[DATA_W-1:0]);
`else
    return $signed(v[DATA_W-1:0]);
`endif
  endfunction

  // Operand steering for the shared multiplier; feedback taps subtract.
  always_comb begin
    mul_c   = '0;
    mul_x   = '0;
    mul_sub = 1'b0;
    case (state_q)
      MAC0: begin mul_c = A1; mul_x = x1_q; end
      MAC1: begin mul_c = A2; mul_x = x2_q; end
      MAC2: begin mul_c = B1; mul_x = y1_q; mul_sub = 1'b1; end
      MAC3: begin mul_c = B2; mul_x = y2_q; mul_sub = 1'b1; end
      default: ;
    endcase
  end

  assign prod  = $signed({{(ACC_W-COEF_W){mul_c[COEF_W-1]}}, mul_c})
               * $signed({{(ACC_W-DATA_W){mul_x[DATA_W-1]}}, mul_x});
  assign term  = prod >>> SHIFT;
  assign acc_d = mul_sub ? (acc_q - term) : (acc_q + term);

  assign nrm_prod  = $signed({{(NRM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q})
                   * $signed({{(NRM_W-COEF_W){B0_INV[COEF_W-1]}}, B0_INV});
  assign nrm_shift = nrm_prod >>> SHIFT;
  assign y_red     = reduce(nrm_shift);

  assign bus.ready_in   = (state_q == IDLE);
  assign bus.sample_out = sample_out_q;
  assign bus.valid_out  = valid_out_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      x_cur_q      <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      y1_q         <= '0;
      y2_q         <= '0;
      y_res_q      <= '0;
      sample_out_q <= '0;
      valid_out_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_in) begin
            x_cur_q <= bus.sample_in;
            acc_q   <= {{(ACC_W-DATA_W){bus.sample_in[DATA_W-1]}}, bus.sample_in};
            state_q <= MAC0;
          end
        end
        // MAC stages: one product folded into the accumulator per cycle
        MAC0: begin acc_q <= acc_d; state_q <= MAC1; end
        MAC1: begin acc_q <= acc_d; state_q <= MAC2; end
        MAC2: begin acc_q <= acc_d; state_q <= MAC3; end
        MAC3: begin acc_q <= acc_d; state_q <= NORM; end
        // NORM: gain, reduce, and present the result so it is valid in OUT
        NORM: begin
          y_res_q      <= y_red;
          sample_out_q <= y_red;
          valid_out_q  <= 1'b1;
          state_q      <= OUT;
        end
        // OUT: pulse ends, history advances using exactly the emitted value
        OUT: begin
          valid_out_q <= 1'b0;
          x2_q        <= x1_q;
          x1_q        <= x_cur_q;
          y2_q        <= y1_q;
          y1_q        <= y_res_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_biquad_seq.sv
// tb_inverse_biquad_seq
//   Four filter instances share clock, reset and input stimulus; each one is
//   configured for a different coefficient set and checked against directed,
//   hand-computed expectations.
module tb_inverse_biquad_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               vin;
  logic signed [31:0] sin;

  inverse_biquad_seq_if bus_id ();
  inverse_biquad_seq_if bus_a1 ();
  inverse_biquad_seq_if bus_b1 ();
  inverse_biquad_seq_if bus_g2 ();

  assign bus_id.valid_in = vin;  assign bus_id.sample_in = sin;
  assign bus_a1.valid_in = vin;  assign bus_a1.sample_in = sin;
  assign bus_b1.valid_in = vin;  assign bus_b1.sample_in = sin;
  assign bus_g2.valid_in = vin;  assign bus_g2.sample_in = sin;

  inverse_biquad_seq u_id (.clk_in(clk), .rst_in(rst), .bus(bus_id.slave));
  inverse_biquad_seq #(.A1(32'sh0010_0000)) u_a1 (.clk_in(clk), .rst_in(rst), .bus(bus_a1.slave));
  inverse_biquad_seq #(.B1(-32'sh0008_0000)) u_b1 (.clk_in(clk), .rst_in(rst), .bus(bus_b1.slave));
  inverse_biquad_seq #(.B0_INV(32'sh0020_0000)) u_g2 (.clk_in(clk), .rst_in(rst), .bus(bus_g2.slave));

  logic [31:0] so [4];
  logic        vo [4];
  assign so[0] = bus_id.sample_out;  assign vo[0] = bus_id.valid_out;
  assign so[1] = bus_a1.sample_out;  assign vo[1] = bus_a1.valid_out;
  assign so[2] = bus_b1.sample_out;  assign vo[2] = bus_b1.valid_out;
  assign so[3] = bus_g2.sample_out;  assign vo[3] = bus_g2.valid_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] res [4];

  typedef struct {
    bit          rst_first;
    int          sel;
    logic [31:0] x;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  logic        collect = 1'b0;
  logic [31:0] q_id [$];
  logic [31:0] q_a1 [$];

  always @(negedge clk) begin
    if (collect && vo[0]) begin
      q_id.push_back(so[0]);
      q_a1.push_back(so[1]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", {31'd0, bus_id.ready_in}, 32'd1);
    check("rst_vout", {31'd0, vo[0]}, 32'd0);
    check("rst_sout", so[0], 32'd0);
  endtask

  // Called #1 after a posedge; returns #1 after the edge that starts OUT.
  task automatic xfer(input logic [31:0] x);
    int n;
    int lat;
    vin = 1'b1;
    sin = x;
    n = 0;
    while (!bus_id.ready_in && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_seen", {31'd0, bus_id.ready_in}, 32'd1);
    @(posedge clk); #1;
    vin = 1'b0;
    lat = 1;
    while (!vo[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 32'd6);
    for (int i = 0; i < 4; i++) res[i] = so[i];
  endtask

  initial begin
    logic [31:0] exp_g2;
    int          acc_cyc [$];
    logic [31:0] acc_x [$];
    int          saw;
    logic [31:0] ex1;

`ifdef INVBIQ_SATURATE_EN
    exp_g2 = 32'h7FFF_FFFF;
`else
    exp_g2 = 32'hE000_0000;
`endif

    vecs[0]  = '{1'b1, 0, 32'd5,          32'd5};
    vecs[1]  = '{1'b0, 0, 32'hFFFF_FFF9,  32'hFFFF_FFF9};
    vecs[2]  = '{1'b0, 0, 32'd1000,       32'd1000};
    vecs[3]  = '{1'b1, 1, 32'd100,        32'd100};
    vecs[4]  = '{1'b0, 1, 32'd200,        32'd300};
    vecs[5]  = '{1'b0, 1, 32'd0,          32'd200};
    vecs[6]  = '{1'b1, 2, 32'd1024,       32'd1024};
    vecs[7]  = '{1'b0, 2, 32'd0,          32'd512};
    vecs[8]  = '{1'b0, 2, 32'd0,          32'd256};
    vecs[9]  = '{1'b0, 2, 32'd0,          32'd128};
    vecs[10] = '{1'b0, 2, 32'd0,          32'd64};
    vecs[11] = '{1'b1, 3, 32'h7000_0000,  exp_g2};
    vecs[12] = '{1'b1, 3, 32'd1000,       32'd2000};
    vecs[13] = '{1'b1, 2, 32'hFFFF_FC00,  32'hFFFF_FC00};
    vecs[14] = '{1'b0, 2, 32'd0,          32'hFFFF_FE00};

    rst = 1'b1;
    vin = 1'b0;
    sin = '0;

    for (int v = 0; v < 15; v++) begin
      if (vecs[v].rst_first) do_reset();
      xfer(vecs[v].x);
      check($sformatf("vec%0d", v), res[vecs[v].sel], vecs[v].exp);
    end

    // valid_out is a single-cycle pulse
    @(posedge clk); #1;
    check("vout_pulse", {31'd0, vo[0]}, 32'd0);

    // Streaming: valid held high with a new sample every cycle
    do_reset();
    q_id.delete();
    q_a1.delete();
    collect = 1'b1;
    for (int i = 0; i < 30; i++) begin
      vin = 1'b1;
      sin = 32'd3000 + i;
      if (bus_id.ready_in) begin
        acc_cyc.push_back(i);
        acc_x.push_back(32'd3000 + i);
      end
      @(posedge clk); #1;
    end
    vin = 1'b0;
    repeat (12) @(posedge clk);
    #1 collect = 1'b0;
    check("stream_accepts", acc_cyc.size(), 32'd5);
    for (int k = 1; k < acc_cyc.size(); k++)
      check($sformatf("stream_gap%0d", k), acc_cyc[k] - acc_cyc[k-1], 32'd7);
    check("stream_outs", q_id.size(), acc_x.size());
    for (int k = 0; k < acc_x.size() && k < q_id.size(); k++) begin
      ex1 = (k == 0) ? 32'd0 : acc_x[k-1];
      check($sformatf("stream_id%0d", k), q_id[k], acc_x[k]);
      check($sformatf("stream_a1_%0d", k), q_a1[k], acc_x[k] + ex1);
    end

    // Reset in the middle of a computation with nonzero history
    do_reset();
    xfer(32'd77);
    check("pre_rst_a1", res[1], 32'd77);
    vin = 1'b1;
    sin = 32'd9;
    saw = 0;
    while (!bus_id.ready_in && saw < 20) begin
      @(posedge clk); #1;
      saw++;
    end
    @(posedge clk); #1;
    vin = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", {31'd0, bus_id.ready_in}, 32'd1);
    check("mid_rst_sout", so[0], 32'd0);
    check("mid_rst_sout_a1", so[1], 32'd0);
    saw = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (vo[0]) saw = 1;
    end
    check("mid_rst_no_vout", saw, 32'd0);
    xfer(32'd50);
    check("post_rst_id", res[0], 32'd50);
    check("post_rst_a1", res[1], 32'd50);
    check("post_rst_b1", res[2], 32'd50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
